// File: rtl/stream_demux_1_4_if.sv
// Handshake bundle for the 1:4 stream demux: one valid/ready input stream,
// four valid/ready output streams and a busy flag.
interface stream_demux_1_4_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out_data0;
    logic [W-1:0] out_data1;
    logic [W-1:0] out_data2;
    logic [W-1:0] out_data3;
    logic         busy;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, busy
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, busy
    );
endinterface

// File: rtl/stream_demux_1_4.sv
// 1:4 stream demux: the input word is steered by in_sel into one of four
// per-channel FIFOs, so a stalled consumer only blocks its own traffic.
module stream_demux_1_4 #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rst_n,
    stream_demux_1_4_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem  [4][DEPTH];
    logic [AW-1:0] rd_ptr [4];
    logic [AW-1:0] wr_ptr [4];
    logic [CW-1:0] cnt    [4];
    logic [W-1:0]  head   [4];

    logic [3:0] full;
    logic [3:0] vld;
    logic [3:0] push;
    logic [3:0] pop;

    always_comb begin
        full = '0;
        vld  = '0;
        push = '0;
        for (int k = 0; k < 4; k++) begin
            full[k] = (cnt[k] == CW'(DEPTH));
            vld[k]  = (cnt[k] != '0);
        end
        if (bus.in_valid && !full[bus.in_sel])
            push[bus.in_sel] = 1'b1;
        pop = vld & bus.out_ready;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (push[k])
                mem[k][wr_ptr[k]] <= bus.in_data;
    end

    // head is a separate register so an emptied channel keeps showing its
    // last word instead of whatever stale slot the read pointer lands on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                cnt[k]    <= '0;
                head[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k])
                    wr_ptr[k] <= wr_ptr[k] + AW'(1);
                if (pop[k])
                    rd_ptr[k] <= rd_ptr[k] + AW'(1);
                case ({push[k], pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + CW'(1);
                    2'b01:   cnt[k] <= cnt[k] - CW'(1);
                    default: cnt[k] <= cnt[k];
                endcase
                if (pop[k] && cnt[k] > CW'(1))
                    head[k] <= mem[k][rd_ptr[k] + AW'(1)];
                else if (push[k] && (cnt[k] == '0 || (pop[k] && cnt[k] == CW'(1))))
                    head[k] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = !full[bus.in_sel];
    assign bus.out_valid = vld;
    assign bus.busy      = |vld;
    assign bus.out_data0 = head[0];
    assign bus.out_data1 = head[1];
    assign bus.out_data2 = head[2];
    assign bus.out_data3 = head[3];
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Randomised and directed bench for stream_demux_1_4 against a queue-based
// model of four independent FIFOs.
module tb_stream_demux_1_4;
    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;

    stream_demux_1_4_if #(.W(W)) bus ();

    stream_demux_1_4 #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] q    [4][$];
    logic [W-1:0] last [4];
    bit           last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] odata(input int k);
        case (k)
            0:       return bus.out_data0;
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            last[k] = '0;
        end
    endtask

    // check every output against the model, then advance one clock
    task automatic cycle();
        logic [3:0] ev;
        logic [3:0] pops;
        bit         acc;
        int         s;
        #1;
        ev = '0;
        for (int k = 0; k < 4; k++) ev[k] = (q[k].size() != 0);
        s = int'(bus.in_sel);
        chk("in_ready", 32'(bus.in_ready), 32'(q[s].size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        chk("busy", 32'(bus.busy), 32'(|ev));
        for (int k = 0; k < 4; k++)
            chk($sformatf("out_data%0d", k), 32'(odata(k)), 32'(last[k]));
        acc  = bus.in_valid && (q[s].size() < DEPTH);
        pops = ev & bus.out_ready;
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (pops[k]) void'(q[k].pop_front());
        if (acc) q[s].push_back(bus.in_data);
        for (int k = 0; k < 4; k++)
            if (q[k].size() != 0) last[k] = q[k][0];
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int sel, input logic [W-1:0] d, input logic [3:0] rdy);
        bus.in_valid  = v;
        bus.in_sel    = 2'(sel);
        bus.in_data   = d;
        bus.out_ready = rdy;
    endtask

    initial begin
        model_clear();
        drive(0, 0, '0, '0);
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(negedge clk);

        // reset state, then a single word to channel 2
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        drive(1, 2, 4'hC, 4'h0);
        cycle();
        chk("single_acc", 32'(last_acc), 32'h1);
        drive(0, 2, 4'hC, 4'h0);
        chk("single_valid", 32'(bus.out_valid), 32'h4);
        chk("single_data", 32'(bus.out_data2), 32'hC);
        drive(0, 0, '0, 4'b0100);
        cycle();
        chk("single_drained", 32'(bus.out_valid), 32'h0);
        chk("single_hold", 32'(bus.out_data2), 32'hC);

        // round robin A..D, then idle with nobody ready
        for (int i = 0; i < 4; i++) begin
            drive(1, i, 4'(4'hA + i), 4'h0);
            cycle();
        end
        drive(0, 0, '0, 4'h0);
        for (int i = 0; i < 5; i++) cycle();
        chk("rr_valid", 32'(bus.out_valid), 32'hF);
        chk("rr_d0", 32'(bus.out_data0), 32'hA);
        chk("rr_d3", 32'(bus.out_data3), 32'hD);
        drive(0, 0, '0, 4'hF);
        cycle();

        // backpressure on channel 1, channel 3 still accepts
        drive(1, 1, 4'h1, 4'h0); cycle();
        drive(1, 1, 4'h2, 4'h0); cycle();
        drive(1, 1, 4'h3, 4'h0); cycle();
        chk("bp_blocked", 32'(last_acc), 32'h0);
        chk("bp_ready_low", 32'(bus.in_ready), 32'h0);
        drive(1, 3, 4'h3, 4'h0); cycle();
        chk("bp_ch3_acc", 32'(last_acc), 32'h1);
        drive(0, 0, '0, 4'b0010); cycle();
        chk("bp_second", 32'(bus.out_data1), 32'h2);
        drive(0, 0, '0, 4'hF); cycle(); cycle();

        // full channel 0 with simultaneous pop: no pass-through
        drive(1, 0, 4'h5, 4'h0); cycle();
        drive(1, 0, 4'h6, 4'h0); cycle();
        drive(1, 0, 4'h7, 4'h1); cycle();
        chk("full_pop_noacc", 32'(last_acc), 32'h0);
        chk("full_pop_head", 32'(bus.out_data0), 32'h6);
        cycle();
        chk("full_pop_acc", 32'(last_acc), 32'h1);
        drive(0, 0, '0, 4'h1); cycle();
        chk("full_pop_last", 32'(bus.out_data0), 32'h7);
        cycle();

        // steady streaming on channel 3, pointers wrap repeatedly
        for (int i = 0; i < 16; i++) begin
            drive(1, 3, 4'(i), 4'h8);
            cycle();
            chk("stream_acc", 32'(last_acc), 32'h1);
        end
        drive(0, 0, '0, 4'h8); cycle();
        chk("stream_end", 32'(bus.out_data3), 32'hF);

        // randomised traffic, honouring hold-while-stalled on the producer
        last_acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(bus.in_valid && !last_acc)) begin
                bus.in_valid = ($urandom_range(3) != 0);
                bus.in_sel   = 2'($urandom_range(3));
                bus.in_data  = 4'($urandom);
            end
            bus.out_ready = 4'($urandom);
            cycle();
        end

        // fill channels 0 and 2, then reset asynchronously between edges
        drive(0, 0, '0, 4'hF); cycle(); cycle(); cycle();
        drive(1, 0, 4'h4, 4'h0); cycle();
        drive(1, 2, 4'h8, 4'h0); cycle();
        drive(0, 0, '0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_d0", 32'(bus.out_data0), 32'h0);
        chk("arst_d2", 32'(bus.out_data2), 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 2, 4'h9, 4'h0); cycle();
        drive(0, 0, '0, 4'h0); cycle();
        chk("arst_new_valid", 32'(bus.out_valid), 32'h4);
        chk("arst_new_d2", 32'(bus.out_data2), 32'h9);
        drive(0, 0, '0, 4'h4); cycle();
        chk("arst_only_one", 32'(bus.out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Inverse of the team's 4:1 selectors: one valid/ready input stream is steered by a 2-bit select to one of four output streams.
- Each output has its own small FIFO, so a stalled consumer blocks only traffic addressed to it.
- Sits between a single producer (command/data source) and four independent consumers.

Parameters:
W, 4, data width of input and each output
DEPTH, 2, entries per output FIFO; power of two, minimum 2

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  block can accept the word addressed by in_sel
in_data  input  W  input word
in_sel  input  2  destination channel 0..3; must be valid whenever in_valid=1
out_valid  output  4  bit k: channel k FIFO non-empty
out_ready  input  4  bit k: consumer k takes the head word
out_data0  output  W  head word of channel 0
out_data1  output  W  head word of channel 1
out_data2  output  W  head word of channel 2
out_data3  output  W  head word of channel 3
busy  output  1  OR of out_valid

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - All FIFOs empty; read/write pointers and counts = 0.
  - out_valid=4'b0000, busy=0, out_data0..3=0.
  - Words in flight are discarded.
  - Release is synchronous to clk; the first accept is possible on the first rising edge after release.
- in_ready is combinational: in_ready = !full[in_sel].
  - Independent of in_valid.
  - Not dependent on a same-cycle pop: a full FIFO does not accept even while popping (no pass-through).
- Push: on a clk edge with in_valid && in_ready, in_data is written to FIFO[in_sel].
  - Nothing is written when in_valid=0 or in_ready=0.
  - Producer must hold in_data/in_sel stable while in_valid && !in_ready.
- Latency: a word accepted at edge N is visible on out_data_k with out_valid[k]=1 after edge N, so out_valid rises one cycle after acceptance. No combinational in->out path.
- Pop: on a clk edge with out_valid[k] && out_ready[k], the channel k head is removed.
  - out_data_k shows the next entry, or holds its last value if the FIFO is now empty.
  - out_ready[k] while out_valid[k]=0 has no effect.
- Hold: while out_valid[k] && !out_ready[k], out_data_k and out_valid[k] are stable.
- Simultaneous push and pop on the same channel:
  - If not full: count unchanged and both operations take effect.
  - If full: push is blocked by in_ready=0; pop proceeds, and in_ready rises the next cycle.
- Channels are fully independent: pushes to one channel and pops on all four may occur in the same cycle.
- Ordering: FIFO order within each channel; no ordering guarantee across channels.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Per-channel count is 0..DEPTH: full when count==DEPTH, empty when count==0.
- Data is passed unmodified; no width conversion.
- busy = |out_valid, derived from registered state.

Test Plan:
- Reset, then in_valid=1, in_sel=2, in_data=4'hC for 1 cycle -> in_ready=1; next cycle out_valid=4'b0100, out_data2=4'hC, busy=1; out_ready[2]=1 one cycle -> out_valid=0, busy=0.
- Round robin: send A,B,C,D with sel 0,1,2,3 on consecutive cycles, all out_ready=0 -> out_valid=4'b1111 with out_data0..3=A,B,C,D; held stable for 5 idle cycles.
- Backpressure, DEPTH=2: send 1,2,3 to channel 1 with out_ready[1]=0 -> words 1 and 2 accepted, in_ready=0 while in_sel=1. Switch in_sel=3 -> in_ready=1 and word 3 is accepted into channel 3. Then pop channel 1 -> 1 then 2 in order.
- Full with simultaneous pop: channel 0 full (5,6), in_valid=1, sel=0, data=7, out_ready[0]=1 -> edge1 pops 5 and 7 is not accepted; edge2 accepts 7; drain order is 6,7.
- Steady streaming: 16 words 0..F to channel 3 with out_ready[3]=1 always -> one word per cycle after a 1-cycle fill, out_data3 sequence 0..F, count never reaches DEPTH, pointers wrap correctly.
- Async reset mid-stream: rst_n low between clk edges with channels 0 and 2 holding data -> out_valid=0 and out_data=0 immediately without a clock edge; after release, a single push to channel 2 yields only the new word.
